// File: rtl/fifo_pkt_tx_pkg.sv
// Shared slot layout offsets and drainer FSM encoding for the router FIFO port logic.
package fifo_pkt_tx_pkg;

    localparam int SRC_OFS  = 0;
    localparam int DST_OFS  = 1;
    localparam int SIZE_OFS = 2;
    localparam int DATA_OFS = 3;
    localparam int HDR_LEN  = 3;
    localparam int TRL_LEN  = 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SZ_A = 3'd1,
        SZ_D = 3'd2,
        RD_A = 3'd3,
        RD_D = 3'd4,
        SEND = 3'd5,
        POP  = 3'd6,
        GAP  = 3'd7
    } tx_state_t;

endpackage

// File: rtl/fifo_pkt_tx_if.sv
// FIFO read side plus byte-serial tx stream of the output-port drainer.
interface fifo_pkt_tx_if #(
    parameter int UWIDTH    = 8,
    parameter int PTR_IN_SZ = 4
) ();
    logic                 rempty;
    logic [UWIDTH-1:0]    rdata;
    logic [PTR_IN_SZ-1:0] raddr_in;
    logic                 rinc;
    logic [UWIDTH-1:0]    tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_sop;
    logic                 tx_eop;

    modport master (
        input  rempty, rdata, tx_ready,
        output raddr_in, rinc, tx_data, tx_valid, tx_sop, tx_eop
    );

    modport slave (
        output rempty, rdata, tx_ready,
        input  raddr_in, rinc, tx_data, tx_valid, tx_sop, tx_eop
    );
endinterface

// File: rtl/fifo_pkt_tx_crc_acc.sv
// Running XOR accumulator over the bytes of one packet.
module pkt_crc_acc #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc
);
    always_ff @(posedge clk) begin
        if (rst || clr) acc <= '0;
        else if (en)    acc <= acc ^ din;
    end
endmodule

// File: rtl/fifo_pkt_tx.sv
// Drains committed packet slots from the FIFO head and streams them byte-serially,
// popping the slot once the crc byte has been handed off.
module fifo_pkt_tx
    import fifo_pkt_tx_pkg::*;
#(
    parameter int WIDTH     = 11,
    parameter int UWIDTH    = 8,
    parameter int PTR_IN_SZ = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk2,
    input  logic             rst,
    fifo_pkt_tx_if.master    bus,
    output logic             crc_err,
    output logic             len_err,
    output logic [CNT_W-1:0] pkt_cnt
);
    localparam logic [UWIDTH-1:0] MAX_SIZE = UWIDTH'(WIDTH - HDR_LEN - TRL_LEN);

    tx_state_t            state_q, state_n;
    logic [UWIDTH-1:0]    size_q, size_n;
    logic [PTR_IN_SZ-1:0] idx_q, idx_n;
    logic [PTR_IN_SZ-1:0] raddr_q, raddr_n;
    logic                 rinc_q, rinc_n;
    logic [UWIDTH-1:0]    txd_q, txd_n;
    logic                 txv_q, txv_n;
    logic                 sop_q, sop_n;
    logic                 eop_q, eop_n;
    logic                 crc_err_q, crc_err_n;
    logic                 len_err_q, len_err_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic                 crc_clr, crc_en;
    logic [UWIDTH-1:0]    crc_acc;
    logic [UWIDTH-1:0]    last_idx;

    // crc byte sits right after header + data
    assign last_idx = size_q + UWIDTH'(HDR_LEN);

    pkt_crc_acc #(.W(UWIDTH)) u_crc (
        .clk (clk2),
        .rst (rst),
        .clr (crc_clr),
        .en  (crc_en),
        .din (txd_q),
        .acc (crc_acc)
    );

    always_comb begin
        state_n   = state_q;
        size_n    = size_q;
        idx_n     = idx_q;
        raddr_n   = raddr_q;
        rinc_n    = 1'b0;
        txd_n     = txd_q;
        txv_n     = txv_q;
        sop_n     = sop_q;
        eop_n     = eop_q;
        crc_err_n = 1'b0;
        len_err_n = 1'b0;
        cnt_n     = cnt_q;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;
        case (state_q)
            IDLE: if (!bus.rempty) begin
                raddr_n = PTR_IN_SZ'(SIZE_OFS);
                state_n = SZ_A;
            end
            SZ_A: state_n = SZ_D;
            SZ_D: begin
                size_n = bus.rdata;
                if (bus.rdata > MAX_SIZE) begin
                    len_err_n = 1'b1;
                    state_n   = POP;
                end else begin
                    idx_n   = PTR_IN_SZ'(SRC_OFS);
                    raddr_n = PTR_IN_SZ'(SRC_OFS);
                    crc_clr = 1'b1;
                    state_n = RD_A;
                end
            end
            RD_A: state_n = RD_D;
            RD_D: begin
                txd_n   = bus.rdata;
                txv_n   = 1'b1;
                sop_n   = (idx_q == PTR_IN_SZ'(SRC_OFS));
                eop_n   = (UWIDTH'(idx_q) == last_idx);
                state_n = SEND;
            end
            SEND: if (bus.tx_ready) begin
                txv_n = 1'b0;
                sop_n = 1'b0;
                eop_n = 1'b0;
                if (eop_q) begin
                    // accumulator holds XOR of every byte before the crc byte
                    crc_err_n = (txd_q != crc_acc);
                    cnt_n     = cnt_q + CNT_W'(1);
                    state_n   = POP;
                end else begin
                    crc_en  = 1'b1;
                    idx_n   = idx_q + PTR_IN_SZ'(1);
                    raddr_n = idx_q + PTR_IN_SZ'(1);
                    state_n = RD_A;
                end
            end
            POP: begin
                rinc_n  = 1'b1;
                state_n = GAP;
            end
            // rempty lags the pop by a cycle, so it is not looked at here
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            state_q   <= IDLE;
            size_q    <= '0;
            idx_q     <= '0;
            raddr_q   <= '0;
            rinc_q    <= 1'b0;
            txd_q     <= '0;
            txv_q     <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            crc_err_q <= 1'b0;
            len_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_n;
            size_q    <= size_n;
            idx_q     <= idx_n;
            raddr_q   <= raddr_n;
            rinc_q    <= rinc_n;
            txd_q     <= txd_n;
            txv_q     <= txv_n;
            sop_q     <= sop_n;
            eop_q     <= eop_n;
            crc_err_q <= crc_err_n;
            len_err_q <= len_err_n;
            cnt_q     <= cnt_n;
        end
    end

    assign bus.raddr_in = raddr_q;
    assign bus.rinc     = rinc_q;
    assign bus.tx_data  = txd_q;
    assign bus.tx_valid = txv_q;
    assign bus.tx_sop   = sop_q;
    assign bus.tx_eop   = eop_q;
    assign crc_err      = crc_err_q;
    assign len_err      = len_err_q;
    assign pkt_cnt      = cnt_q;

endmodule

// File: tb/tb_fifo_pkt_tx.sv
// Randomized bench: queue-based FIFO model feeds slots, a scoreboard checks the stream per slot.
module tb_fifo_pkt_tx;
    localparam int WIDTH = 11;
    localparam int CNT_W = 16;

    typedef logic [WIDTH-1:0][7:0] slot_t;
    typedef logic [7:0] barr_t [];

    logic             clk2 = 1'b0;
    logic             rst;
    logic             crc_err, len_err;
    logic [CNT_W-1:0] pkt_cnt;

    fifo_pkt_tx_if #(.UWIDTH(8), .PTR_IN_SZ(4)) bus ();

    fifo_pkt_tx #(.WIDTH(WIDTH), .UWIDTH(8), .PTR_IN_SZ(4), .CNT_W(CNT_W)) dut (
        .clk2    (clk2),
        .rst     (rst),
        .bus     (bus),
        .crc_err (crc_err),
        .len_err (len_err),
        .pkt_cnt (pkt_cnt)
    );

    always #5 clk2 = ~clk2;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic bit bad_size(input slot_t s);
        return s[2] > 8'(WIDTH - 4);
    endfunction

    function automatic logic [7:0] xor_crc(input slot_t s);
        logic [7:0] x = '0;
        for (int i = 0; i < int'(s[2]) + 3; i++) x ^= s[i];
        return x;
    endfunction

    function automatic slot_t to_slot(input barr_t b);
        slot_t s = '0;
        for (int i = 0; i < b.size(); i++) s[i] = b[i];
        return s;
    endfunction

    function automatic slot_t rand_slot(input logic [7:0] sz, input bit good);
        slot_t s;
        for (int i = 0; i < WIDTH; i++) s[i] = 8'($urandom);
        s[2] = sz;
        if (sz <= 8'(WIDTH - 4)) s[sz + 3] = good ? xor_crc(s) : (xor_crc(s) ^ 8'h5a);
        return s;
    endfunction

    // FIFO read side: registered read, pop on rinc, empty flag updated at the edge
    slot_t fifo_q[$];
    always @(posedge clk2) begin
        if (fifo_q.size() > 0 && int'(bus.raddr_in) < WIDTH) bus.rdata <= fifo_q[0][bus.raddr_in];
        else bus.rdata <= '0;
        if (bus.rinc && fifo_q.size() > 0) void'(fifo_q.pop_front());
        bus.rempty <= (fifo_q.size() == 0);
    end

    // scoreboard
    int               pos = 0;
    bit               done = 0, saw_len = 0, crc_pend = 0, rst_d = 0, prev_hold = 0, rinc_d = 0;
    logic [7:0]       prev_data = '0;
    logic [CNT_W-1:0] exp_cnt = '0;
    int               rinc_cnt = 0, crc_seen = 0, len_seen = 0;

    always @(negedge clk2) begin
        slot_t h;
        int    n;
        if (rst) begin
            pos = 0; done = 0; saw_len = 0; crc_pend = 0; exp_cnt = '0;
            prev_hold = 0; rinc_d = 0; rst_d = 1;
        end else begin
            if (rst_d)
                chk("reset_outputs",
                    {bus.tx_data, bus.tx_valid, bus.tx_sop, bus.tx_eop, bus.rinc,
                     crc_err, len_err, bus.raddr_in, pkt_cnt}, '0);
            chk("pkt_cnt", pkt_cnt, exp_cnt);
            chk("crc_err", crc_err, crc_pend);
            if (crc_err) crc_seen++;
            crc_pend = 0;
            if (prev_hold) chk("hold", {bus.tx_valid, bus.tx_data}, {1'b1, prev_data});
            h = (fifo_q.size() > 0) ? fifo_q[0] : '0;
            n = int'(h[2]);
            if (len_err) begin
                chk("len_err_slot", bad_size(h), 1);
                saw_len = 1;
                len_seen++;
            end
            if (bus.rinc) begin
                chk("rinc_single", rinc_d, 0);
                chk("rinc_after", {saw_len, done}, bad_size(h) ? 2'b10 : 2'b01);
                rinc_cnt++;
                saw_len = 0;
                done = 0;
            end
            if (bus.tx_valid) begin
                chk("valid_on_bad", bad_size(h) || fifo_q.size() == 0, 0);
                chk("byte", {bus.tx_sop, bus.tx_eop, bus.tx_data},
                    {pos == 0, pos == n + 3, (pos < WIDTH) ? h[pos] : 8'h00});
                if (bus.tx_ready) begin
                    if (bus.tx_eop) begin
                        crc_pend = (n + 3 < WIDTH) && (h[n + 3] != xor_crc(h));
                        exp_cnt++;
                        done = 1;
                        pos = 0;
                    end else pos++;
                end
            end
            prev_hold = bus.tx_valid && !bus.tx_ready;
            prev_data = bus.tx_data;
            rinc_d = bus.rinc;
            rst_d = 0;
        end
    end

    task automatic drain(input bit rand_rdy);
        int t = 0;
        while ((fifo_q.size() > 0 || bus.tx_valid) && t < 3000) begin
            @(posedge clk2); #1;
            bus.tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            t++;
        end
        chk("drain_timeout", t < 3000, 1);
        repeat (3) @(posedge clk2);
        #1;
    endtask

    initial begin
        int    stall, t, ngood;
        slot_t s;
        rst = 1'b1;
        bus.tx_ready = 1'b0;
        repeat (3) @(posedge clk2);
        #1 rst = 1'b0;

        // empty FIFO, ready toggling: nothing moves
        repeat (50) begin
            @(posedge clk2); #1;
            bus.tx_ready = 1'($urandom_range(0, 1));
            @(negedge clk2);
            chk("idle", {bus.tx_valid, bus.rinc, bus.raddr_in}, '0);
        end

        // good packet
        fifo_q.push_back(to_slot('{10, 160, 3, 0, 1, 2, 170}));
        drain(0);
        chk("t1_cnt", pkt_cnt, 1);
        chk("t1_rinc", rinc_cnt, 1);
        chk("t1_crc", crc_seen, 0);

        // bad crc byte: still sent and counted
        fifo_q.push_back(to_slot('{10, 160, 3, 0, 1, 2, 15}));
        drain(0);
        chk("t2_cnt", pkt_cnt, 2);
        chk("t2_crc", crc_seen, 1);

        // oversize slot dropped
        fifo_q.push_back(to_slot('{1, 2, 8, 3, 4, 5, 6, 7, 8, 9, 10}));
        drain(0);
        chk("t3_cnt", pkt_cnt, 2);
        chk("t3_rinc", rinc_cnt, 3);
        chk("t3_len", len_seen, 1);

        // backpressure on the size byte
        fifo_q.push_back(to_slot('{100, 10, 4, 0, 1, 2, 3, 106}));
        stall = 0; t = 0;
        while ((fifo_q.size() > 0) && t < 3000) begin
            @(posedge clk2); #1;
            t++;
            if (bus.tx_valid && bus.tx_data == 8'd4 && stall < 5) begin
                bus.tx_ready = 1'b0;
                stall++;
            end else bus.tx_ready = bus.tx_valid;
        end
        chk("t4_stall", stall, 5);
        drain(0);
        chk("t4_cnt", pkt_cnt, 3);
        chk("t4_crc", crc_seen, 1);

        // reset after byte 2 handed off; slot restarts from source_id
        fifo_q.push_back(to_slot('{1, 2, 3, 10, 20, 30, 8'h09}));
        bus.tx_ready = 1'b1;
        t = 0;
        while (pos != 3 && t < 1000) begin @(posedge clk2); #1; t++; end
        chk("t5_reach", t < 1000, 1);
        rst = 1'b1;
        @(posedge clk2); #1 rst = 1'b0;
        chk("t5_norinc", rinc_cnt, 4);
        drain(0);
        chk("t5_cnt", pkt_cnt, 1);
        chk("t5_rinc", rinc_cnt, 5);

        // four back-to-back slots
        for (int i = 0; i < 4; i++) fifo_q.push_back(rand_slot(8'($urandom_range(0, 7)), 1));
        drain(0);
        chk("t6_cnt", pkt_cnt, 5);
        chk("t6_rinc", rinc_cnt, 9);

        // random mix with random backpressure
        ngood = 0;
        for (int i = 0; i < 20; i++) begin
            s = rand_slot(8'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
            if (!bad_size(s)) ngood++;
            fifo_q.push_back(s);
            if ($urandom_range(0, 2) == 0) drain(1);
        end
        drain(1);
        chk("t7_cnt", pkt_cnt, 5 + ngood);
        chk("t7_rinc", rinc_cnt, 29);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
